hc595_chain_ctrl: RTL and testbench
===================================

Name: hc595_chain_ctrl

Overview:
Parametrised serial driver for a daisy-chain of 74HC595 shift registers, such as the 6-bit digit-select plus 8-bit segment word of the seven-segment board. It accepts a parallel word through a valid/ready handshake and shifts it out on ds/shcp at a programmable rate. It then pulses stcp to latch the word and controls oe, holding outputs blank until the first complete frame has been latched. Seg display top levels place it between the display-pattern generator and the board pins.

Parameters:
DATA_W, 14, total bits in the chain (6 sel + 8 seg); must be >= 1
DIV_HALF, 2, sys_clk cycles per shcp half-period; must be >= 1
MSB_FIRST, 1, 1 = data_in[DATA_W-1] shifted first; 0 = data_in[0] first

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
data_in  in  DATA_W  parallel word to transmit
load_valid  in  1  data_in is valid
load_ready  out  1  block can accept a word
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after stcp falls
oe_en  in  1  1 = enable 595 outputs (after first frame)
ds  out  1  serial data to 595 chain
shcp  out  1  shift clock
stcp  out  1  storage/latch clock
oe  out  1  595 output enable, active-low

Behaviour:
- Interface decision: one clock, sys_clk; reset sys_rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: load_ready=0, busy=0, frame_done=0, ds=0, shcp=0, stcp=0, oe=1. Internal state is IDLE, counters are 0, and the first_done flag is 0.
- load_ready rises on the first sys_clk edge after reset release.
- FSM states:
  - IDLE: load_ready=1, busy=0. A transfer is accepted on an edge where load_valid && load_ready. On acceptance, capture data_in into the shift register, drop load_ready, set busy, and go to SHIFT.
  - SHIFT: phase counter runs 0..2*DIV_HALF-1; bit counter runs 0..DATA_W-1.
    - Phase 0: ds is driven with the current bit.
    - Phases 0..DIV_HALF-1: shcp=0.
    - Phases DIV_HALF..2*DIV_HALF-1: shcp=1, giving a rising edge mid-bit with ds stable for DIV_HALF cycles beforehand.
    - At the last phase of the last bit, go to LATCH with shcp returning to 0.
  - LATCH: stcp=1 for DIV_HALF cycles, then stcp=0. Go to DONE.
  - DONE: frame_done=1 for exactly one cycle, first_done is set, busy clears, load_ready=1. Go to IDLE.
- Frame timing: from the acceptance edge, SHIFT occupies DATA_W*2*DIV_HALF cycles, LATCH occupies DIV_HALF cycles, and DONE occupies 1 cycle.
- Shift order:
  - MSB_FIRST=1: shift left, ds = reg[DATA_W-1].
  - MSB_FIRST=0: shift right, ds = reg[0].
  - The register is advanced at the last phase of each bit.
- ds is held at the last shifted bit value outside SHIFT.
- oe = ~(oe_en && first_done), registered. The 595 outputs stay blank until the first frame has latched, then follow oe_en with 1-cycle latency. oe is independent of the FSM after that.
- Counter widths: phase counter is $clog2(2*DIV_HALF) bits (minimum 1); bit counter is $clog2(DATA_W) bits (minimum 1). There is no wrap beyond the terminal counts.
- load_valid while busy: ignored, and data_in is not sampled.
- load_valid held high continuously: back-to-back frames, with the next acceptance in the cycle after DONE.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded, stcp is never pulsed, and first_done clears, so oe returns to 1.
- DATA_W=1 and DIV_HALF=1 are legal. In that case shcp toggles every cycle.

Decomposition:
- Package hc595_pkg: FSM state enum (IDLE, SHIFT, LATCH, DONE) and a helper function for counter width.
- Sub-module hc595_bit_timer: phase/bit counters emitting bit_start, shcp_rise and last_bit_end strobes; the parent FSM consumes these strobes.

Test Plan (all scenarios use DATA_W=14, DIV_HALF=2, MSB_FIRST=1 unless stated):
1. Reset release, then a load of data_in=14'h2A5C. Required:
   - load_ready rises on the 1st edge after release.
   - 14 shcp rising edges occur, each 4 cycles apart.
   - ds sampled at the shcp rises reads 10_1010_0101_1100.
   - stcp is high for 2 cycles.
   - frame_done pulses 59 cycles after acceptance.
2. MSB_FIRST=0, data_in=14'h0001. Required: ds=1 at the first shcp rise and 0 at the remaining 13 rises.
3. oe_en=1 from reset. Required: oe=1 until the cycle after the first frame_done, then 0. Driving oe_en=0 then gives oe=1 one cycle later.
4. load_valid pulsed mid-frame with data 14'h3FFF. Required: it is ignored, the current frame completes unchanged, and no second frame starts.
5. load_valid held high with alternating data. Required: frames are back-to-back, with acceptance in the cycle after each frame_done; busy stays low exactly 1 cycle between frames.
6. sys_rst asserted at bit 7 of a frame. Required: ds/shcp/stcp/busy go to 0 asynchronously, oe goes to 1, and stcp is never pulsed. After release, a new frame transmits correctly.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package hc595_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch,
        StDone
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hc595_bit_timer.sv
// Phase/bit counters pacing the serial frame; emits per-bit timing strobes.
module hc595_bit_timer
    import hc595_pkg::*;
#(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned DIV_HALF = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    output logic bit_start,
    output logic shcp_rise,
    output logic bit_end,
    output logic last_bit_end
);

    localparam int unsigned PH_W  = cnt_w(2 * DIV_HALF);
    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * DIV_HALF - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(DIV_HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    // Counters idle at zero and only advance while the frame is shifting.
    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        if (!run) begin
            phase_d = '0;
            bit_d   = '0;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
            bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_start    = run && (phase_q == '0);
    assign shcp_rise    = run && (phase_q == PH_RISE);
    assign bit_end      = run && (phase_q == PH_LAST);
    assign last_bit_end = bit_end && (bit_q == BIT_LAST);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a 74HC595 daisy chain: shift, latch, then enable outputs.
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned DIV_HALF  = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              busy,
    output logic              frame_done,
    input  logic              oe_en,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe
);

    localparam int unsigned LAT_W = cnt_w(DIV_HALF);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DIV_HALF - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              first_done_q, first_done_d;
    logic              load_ready_q, load_ready_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              ds_q, ds_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              oe_q, oe_d;

    logic bit_start, shcp_rise, bit_end, last_bit_end;

    hc595_bit_timer #(
        .DATA_W   (DATA_W),
        .DIV_HALF (DIV_HALF)
    ) u_bit_timer (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .run          (state_q == StShift),
        .bit_start    (bit_start),
        .shcp_rise    (shcp_rise),
        .bit_end      (bit_end),
        .last_bit_end (last_bit_end)
    );

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        lat_cnt_d    = lat_cnt_q;
        first_done_d = first_done_q;
        load_ready_d = load_ready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        ds_d         = ds_q;
        shcp_d       = shcp_q;
        stcp_d       = 1'b0;
        // Outputs stay blank until a full frame has been latched.
        oe_d         = ~(oe_en & first_done_q);

        case (state_q)
            StIdle: begin
                load_ready_d = 1'b1;
                busy_d       = 1'b0;
                shcp_d       = 1'b0;
                if (load_valid && load_ready_q) begin
                    shreg_d      = data_in;
                    load_ready_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = StShift;
                end
            end
            StShift: begin
                busy_d       = 1'b1;
                load_ready_d = 1'b0;
                if (bit_start) begin
                    ds_d   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
                    shcp_d = 1'b0;
                end
                if (shcp_rise) begin
                    shcp_d = 1'b1;
                end
                if (bit_end) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                end
                if (last_bit_end) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                shcp_d = 1'b0;
                stcp_d = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StDone: begin
                frame_done_d = 1'b1;
                first_done_d = 1'b1;
                busy_d       = 1'b0;
                load_ready_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            lat_cnt_q    <= '0;
            first_done_q <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ds_q         <= 1'b0;
            shcp_q       <= 1'b0;
            stcp_q       <= 1'b0;
            oe_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            lat_cnt_q    <= lat_cnt_d;
            first_done_q <= first_done_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            ds_q         <= ds_d;
            shcp_q       <= shcp_d;
            stcp_q       <= stcp_d;
            oe_q         <= oe_d;
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ds         = ds_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign oe         = oe_q;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl (14-bit chain, DIV_HALF=2).
module tb_hc595_chain_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] data_in, data_in1;
    logic        load_valid, load_valid1, oe_en, oe_en1;
    logic        load_ready, busy, frame_done, ds, shcp, stcp, oe;
    logic        load_ready1, busy1, frame_done1, ds1, shcp1, stcp1, oe1;

    int total = 0;
    int bad   = 0;

    // Capture results, indexed by edge count after the acceptance edge.
    int   rise_k[$];
    logic rise_ds[$];
    int   fd_k[$];
    int   stcp_hi;
    logic oe_s[0:80];
    logic busy_s[0:80];
    logic lr_s[0:80];

    always #5 sys_clk = ~sys_clk;

    hc595_chain_ctrl #(
        .DATA_W    (14),
        .DIV_HALF  (2),
        .MSB_FIRST (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .oe_en      (oe_en),
        .ds         (ds),
        .shcp       (shcp),
        .stcp       (stcp),
        .oe         (oe)
    );

    hc595_chain_ctrl #(
        .DATA_W    (14),
        .DIV_HALF  (2),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_in    (data_in1),
        .load_valid (load_valid1),
        .load_ready (load_ready1),
        .busy       (busy1),
        .frame_done (frame_done1),
        .oe_en      (oe_en1),
        .ds         (ds1),
        .shcp       (shcp1),
        .stcp       (stcp1),
        .oe         (oe1)
    );

    // Record n edges of the main DUT; optionally pulse load_valid at edge pulse_at.
    task automatic capture(input int n, input int pulse_at);
        logic prev;
        rise_k.delete();
        rise_ds.delete();
        fd_k.delete();
        stcp_hi = 0;
        prev = shcp;
        for (int k = 1; k <= n; k++) begin
            @(posedge sys_clk); #1;
            if (shcp && !prev) begin
                rise_k.push_back(k);
                rise_ds.push_back(ds);
            end
            prev = shcp;
            if (stcp) stcp_hi++;
            if (frame_done) fd_k.push_back(k);
            oe_s[k]   = oe;
            busy_s[k] = busy;
            lr_s[k]   = load_ready;
            if (k == pulse_at) begin
                load_valid = 1'b1;
                data_in    = 14'h3FFF;
            end
            if (k == pulse_at + 1) load_valid = 1'b0;
        end
    endtask

    // Present a word at the negedge; return #1 after the acceptance edge.
    task automatic start_frame(input logic [13:0] d, input logic keep_valid);
        @(negedge sys_clk);
        data_in    = d;
        load_valid = 1'b1;
        @(posedge sys_clk); #1;
        load_valid = keep_valid;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        total++;
        if ({load_ready, busy, frame_done, ds, shcp, stcp, oe} !== 7'b0000001) begin
            bad++;
            $display("FAIL reset_values got=%b want=0000001",
                     {load_ready, busy, frame_done, ds, shcp, stcp, oe});
        end
        sys_rst = 1'b0;
        #1;
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b want=0", load_ready);
        end
        @(posedge sys_clk); #1;
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_first_edge got=%b want=1", load_ready);
        end
    endtask

    task automatic test_frame(input logic [13:0] d, input string tag);
        logic oe_ok;
        start_frame(d, 1'b0);
        total++;
        if (busy !== 1'b1 || load_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s accept got busy=%b ready=%b want 1/0", tag, busy, load_ready);
        end
        capture(62, -1);
        total++;
        if (rise_k.size() != 14) begin
            bad++;
            $display("FAIL %s rise_count got=%0d want=14", tag, rise_k.size());
        end
        for (int i = 0; i < rise_k.size() && i < 14; i++) begin
            total++;
            if (rise_k[i] != 3 + 4 * i || rise_ds[i] !== d[13-i]) begin
                bad++;
                $display("FAIL %s rise%0d got edge=%0d ds=%b want edge=%0d ds=%b",
                         tag, i, rise_k[i], rise_ds[i], 3 + 4 * i, d[13-i]);
            end
        end
        total++;
        if (stcp_hi != 2) begin
            bad++;
            $display("FAIL %s stcp_cycles got=%0d want=2", tag, stcp_hi);
        end
        total++;
        if (fd_k.size() != 1 || fd_k[0] != 59) begin
            bad++;
            $display("FAIL %s frame_done got count=%0d first=%0d want 1 at 59", tag,
                     fd_k.size(), (fd_k.size() > 0) ? fd_k[0] : -1);
        end
        oe_ok = 1'b1;
        for (int k = 1; k <= 59; k++) if (oe_s[k] !== 1'b1) oe_ok = 1'b0;
        total++;
        if (!oe_ok || oe_s[60] !== 1'b0) begin
            bad++;
            $display("FAIL %s oe_release got ok=%b oe60=%b want 1/0", tag, oe_ok, oe_s[60]);
        end
    endtask

    task automatic test_oe_toggle();
        @(negedge sys_clk);
        oe_en = 1'b0;
        total++;
        if (oe !== 1'b0) begin
            bad++;
            $display("FAIL oe_before_toggle got=%b want=0", oe);
        end
        @(posedge sys_clk); #1;
        total++;
        if (oe !== 1'b1) begin
            bad++;
            $display("FAIL oe_disable got=%b want=1", oe);
        end
        @(negedge sys_clk);
        oe_en = 1'b1;
        @(posedge sys_clk); #1;
        total++;
        if (oe !== 1'b0) begin
            bad++;
            $display("FAIL oe_reenable got=%b want=0", oe);
        end
    endtask

    task automatic test_lsb_first();
        int   n_rise;
        logic prev;
        logic ok;
        @(negedge sys_clk);
        data_in1    = 14'h0001;
        load_valid1 = 1'b1;
        @(posedge sys_clk); #1;
        load_valid1 = 1'b0;
        n_rise = 0;
        ok     = 1'b1;
        prev   = shcp1;
        for (int k = 1; k <= 62; k++) begin
            @(posedge sys_clk); #1;
            if (shcp1 && !prev) begin
                if (ds1 !== ((n_rise == 0) ? 1'b1 : 1'b0)) ok = 1'b0;
                n_rise++;
            end
            prev = shcp1;
        end
        total++;
        if (n_rise != 14 || !ok) begin
            bad++;
            $display("FAIL lsb_first got rises=%0d bits_ok=%b want 14/1", n_rise, ok);
        end
    endtask

    task automatic test_ignore_midframe();
        logic [13:0] d;
        d = 14'h0F0F;
        start_frame(d, 1'b0);
        capture(64, 20);
        total++;
        if (rise_k.size() != 14) begin
            bad++;
            $display("FAIL midframe rise_count got=%0d want=14", rise_k.size());
        end
        for (int i = 0; i < rise_k.size() && i < 14; i++) begin
            total++;
            if (rise_ds[i] !== d[13-i]) begin
                bad++;
                $display("FAIL midframe bit%0d got=%b want=%b", i, rise_ds[i], d[13-i]);
            end
        end
        total++;
        if (fd_k.size() != 1 || busy_s[60] !== 1'b0 || busy_s[63] !== 1'b0) begin
            bad++;
            $display("FAIL midframe no_second got fd=%0d busy60=%b busy63=%b want 1/0/0",
                     fd_k.size(), busy_s[60], busy_s[63]);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] d1, d2;
        d1 = 14'h1555;
        d2 = 14'h2AAA;
        start_frame(d1, 1'b1);
        data_in = d2;
        capture(60, -1);
        total++;
        if (busy_s[58] !== 1'b1 || busy_s[59] !== 1'b0 || busy_s[60] !== 1'b1) begin
            bad++;
            $display("FAIL b2b busy_gap got=%b%b%b want=101", busy_s[58], busy_s[59], busy_s[60]);
        end
        total++;
        if (fd_k.size() != 1 || fd_k[0] != 59 || lr_s[60] !== 1'b0) begin
            bad++;
            $display("FAIL b2b handoff got fd=%0d ready60=%b want 1 at 59 / 0",
                     fd_k.size(), lr_s[60]);
        end
        for (int i = 0; i < rise_k.size() && i < 14; i++) begin
            total++;
            if (rise_ds[i] !== d1[13-i]) begin
                bad++;
                $display("FAIL b2b f1 bit%0d got=%b want=%b", i, rise_ds[i], d1[13-i]);
            end
        end
        load_valid = 1'b0;
        data_in    = d1;
        capture(62, -1);
        total++;
        if (rise_k.size() != 14 || fd_k.size() != 1 || fd_k[0] != 59) begin
            bad++;
            $display("FAIL b2b f2 shape got rises=%0d fd=%0d want 14/1",
                     rise_k.size(), fd_k.size());
        end
        for (int i = 0; i < rise_k.size() && i < 14; i++) begin
            total++;
            if (rise_ds[i] !== d2[13-i]) begin
                bad++;
                $display("FAIL b2b f2 bit%0d got=%b want=%b", i, rise_ds[i], d2[13-i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic stcp_seen;
        start_frame(14'h3FC0, 1'b0);
        repeat (31) @(posedge sys_clk);
        #1;
        total++;
        if ({ds, shcp, busy} !== 3'b111) begin
            bad++;
            $display("FAIL midreset pre got ds/shcp/busy=%b want=111", {ds, shcp, busy});
        end
        sys_rst = 1'b1;
        #1;
        total++;
        if ({ds, shcp, stcp, busy, oe} !== 5'b00001) begin
            bad++;
            $display("FAIL midreset async got=%b want=00001", {ds, shcp, stcp, busy, oe});
        end
        stcp_seen = 1'b0;
        repeat (3) begin
            @(posedge sys_clk); #1;
            if (stcp) stcp_seen = 1'b1;
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) begin
            @(posedge sys_clk); #1;
            if (stcp) stcp_seen = 1'b1;
        end
        total++;
        if (stcp_seen || busy !== 1'b0 || oe !== 1'b1 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset after got stcp=%b busy=%b oe=%b ready=%b want 0/0/1/1",
                     stcp_seen, busy, oe, load_ready);
        end
        test_frame(14'h2A5C, "post_reset");
    endtask

    initial begin
        sys_rst     = 1'b1;
        data_in     = '0;
        data_in1    = '0;
        load_valid  = 1'b0;
        load_valid1 = 1'b0;
        oe_en       = 1'b1;
        oe_en1      = 1'b0;
        test_reset();
        test_frame(14'h2A5C, "frame1");
        test_oe_toggle();
        test_lsb_first();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
